// File: rtl/light_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : light_ctrl_pkg
// Brief    : Shared light state / mode encodings for the light controller.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
package light_ctrl_pkg;

  // 2'b00 is deliberately unused so a corrupted state is detectable.
  typedef enum logic [1:0] {
    LS_OFF   = 2'b10,
    LS_ON    = 2'b01,
    LS_BLINK = 2'b11
  } light_state_t;

  localparam logic [1:0] LM_TOGGLE    = 2'b00;
  localparam logic [1:0] LM_MOMENTARY = 2'b01;
  localparam logic [1:0] LM_BLINK     = 2'b10;

endpackage
`default_nettype wire

// File: rtl/light_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : light_btn_debounce
// Brief    : One channel: 2-flop synchroniser, debounce counter, press pulse.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module light_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_btn_s;
  logic             r_deb;
  logic             r_deb_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn;
      r_btn_s <= r_sync1;
      // Any sample that agrees with the accepted level restarts the count.
      if (r_btn_s != r_deb) begin
        if (r_cnt == c_cnt_last) begin
          r_deb <= r_btn_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
    end
  end

  // Delayed level lines up with the press pulse, so momentary and
  // press-driven modes reach the light with the same latency.
  assign level     = r_deb_d;
  assign press_evt = r_press;

endmodule
`default_nettype wire

// File: rtl/light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : light_ctrl
// Brief    : Multi-channel push-button light controller (toggle/momentary/blink).
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module light_ctrl
  import light_ctrl_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int BLINK_HALF_PERIOD = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     btn,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic                    all_off,
  output logic [CHANNELS-1:0]     light,
  output logic [2*CHANNELS-1:0]   state_o,
  output logic [CHANNELS-1:0]     press_evt
);

  localparam int BLK_W = $clog2(BLINK_HALF_PERIOD);
  localparam logic [BLK_W-1:0] c_blk_last = BLK_W'(BLINK_HALF_PERIOD - 1);

  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_blink_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blk_cnt     <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blk_cnt == c_blk_last) begin
      r_blk_cnt     <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic         w_level;
    logic         w_press;
    logic [1:0]   w_mode;
    light_state_t r_state;
    light_state_t w_state_nxt;

    assign w_mode = mode[2*i +: 2];

    light_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn[i]),
      .level    (w_level),
      .press_evt(w_press)
    );

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= LS_OFF;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    always_comb begin
      w_state_nxt = (r_state inside {LS_OFF, LS_ON, LS_BLINK}) ? r_state : LS_OFF;
      if (all_off) begin
        w_state_nxt = LS_OFF;
      end else if (w_mode == LM_MOMENTARY) begin
        w_state_nxt = w_level ? LS_ON : LS_OFF;
      end else if (w_press) begin
        // Reserved mode 2'b11 falls into the toggle branch.
        if (w_mode == LM_BLINK) begin
          w_state_nxt = (r_state == LS_OFF) ? LS_BLINK : LS_OFF;
        end else begin
          w_state_nxt = (r_state == LS_OFF) ? LS_ON : LS_OFF;
        end
      end
    end

    always_comb begin
      light[i] = 1'b0;
      case (r_state)
        LS_ON:    light[i] = 1'b1;
        LS_BLINK: light[i] = r_blink_phase;
        default:  light[i] = 1'b0;
      endcase
    end

    assign state_o[2*i +: 2] = r_state;
    assign press_evt[i]      = w_press;
  end

endmodule
`default_nettype wire
